// File: rtl/hiscore_save_if.sv
// Host download/upload port of the hiscore save block.
// The host side drives the strobes and the address; the block returns upload data.
interface hiscore_save_if;
   logic        ioctl_download;
   logic        ioctl_upload;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic [7:0]  ioctl_index;
   logic [7:0]  ioctl_din;

   modport master (
      output ioctl_download, ioctl_upload, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
      input  ioctl_din
   );

   modport slave (
      input  ioctl_download, ioctl_upload, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
      output ioctl_din
   );
endinterface

// File: rtl/hiscore_save.sv
// Snapshots configured game-RAM regions into a small buffer and serves the
// snapshot back to the host during an upload.
module hiscore_save #(
   parameter int CFG_INDEX   = 3,
   parameter int MAX_ENTRIES = 16,
   parameter int BUF_AW      = 5,
   parameter int RAM_AW      = 10
) (
   input  logic              clk,
   input  logic              reset_n,
   hiscore_save_if.slave     ioctl,
   input  logic              capture_req,
   output logic              capture_busy,
   output logic              capture_done,
   output logic              truncated,
   output logic [RAM_AW-1:0] ram_address,
   output logic              ram_read,
   input  logic [7:0]        ram_data
);

   localparam int IDX_W = (MAX_ENTRIES > 1) ? $clog2(MAX_ENTRIES) : 1;
   localparam int CNT_W = IDX_W + 1;
   localparam logic [BUF_AW:0] BUF_FULL = (BUF_AW+1)'(2**BUF_AW);

   typedef enum logic [2:0] {IDLE, SETUP, READ, STORE, NEXT, DONE} state_t;

   state_t            state, state_nx;
   logic              set_trunc;
   logic [IDX_W-1:0]  entry_idx;
   logic [CNT_W-1:0]  entry_cnt;
   logic [BUF_AW:0]   wr_ptr;
   logic [7:0]        offset;
   logic [23:0]       cur_base;
   logic [7:0]        cur_len;
   logic [23:0]       rd_addr_full;
   logic              unused_addr_bits;

   logic [7:0] tbl_b1  [MAX_ENTRIES];
   logic [7:0] tbl_b2  [MAX_ENTRIES];
   logic [7:0] tbl_b3  [MAX_ENTRIES];
   logic [7:0] tbl_len [MAX_ENTRIES];
   logic [7:0] cap_buf [2**BUF_AW];

   logic             cfg_wr, cfg_in_range, cnt_hit, cfg_seen;
   logic [3:0]       cfg_n;
   logic [2:0]       cfg_k;
   logic [IDX_W-1:0] cfg_idx;
   logic [CNT_W-1:0] cnt_cand;
   logic             abort, more_bytes;

   assign cfg_wr       = ioctl.ioctl_download & ioctl.ioctl_wr &
                         (ioctl.ioctl_index == 8'(CFG_INDEX));
   assign cfg_n        = ioctl.ioctl_addr[6:3];
   assign cfg_k        = ioctl.ioctl_addr[2:0];
   assign cfg_in_range = int'(cfg_n) < MAX_ENTRIES;
   assign cfg_idx      = IDX_W'(cfg_n);
   assign cnt_hit      = cfg_in_range && (cfg_k == 3'd4);
   assign cnt_cand     = CNT_W'(cfg_n) + 1'b1;
   assign abort        = ioctl.ioctl_download | ioctl.ioctl_upload;
   assign more_bytes   = (9'(offset) + 9'd1) < 9'(cur_len);

   // NOTE: the config table and capture buffer are plain storage with no reset;
   // every read of them is qualified by state that is reset.
   always_ff @(posedge clk) begin
      if (cfg_wr && cfg_in_range) begin
         case (cfg_k)
            3'd1:    tbl_b1[cfg_idx]  <= ioctl.ioctl_dout;
            3'd2:    tbl_b2[cfg_idx]  <= ioctl.ioctl_dout;
            3'd3:    tbl_b3[cfg_idx]  <= ioctl.ioctl_dout;
            3'd4:    tbl_len[cfg_idx] <= ioctl.ioctl_dout;
            default: ;
         endcase
      end
      if (state == STORE) cap_buf[wr_ptr[BUF_AW-1:0]] <= ram_data;
   end

   // The first config write of a download restarts the entry count.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         entry_cnt <= '0;
         cfg_seen  <= 1'b0;
      end else begin
         if (!ioctl.ioctl_download) cfg_seen <= 1'b0;
         else if (cfg_wr)           cfg_seen <= 1'b1;
         if (cfg_wr) begin
            if (!cfg_seen)                             entry_cnt <= cnt_hit ? cnt_cand : '0;
            else if (cnt_hit && cnt_cand > entry_cnt)  entry_cnt <= cnt_cand;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_nx  = state;
      set_trunc = 1'b0;
      case (state)
         IDLE:  if (capture_req && entry_cnt != '0 && !abort) state_nx = SETUP;
         SETUP: begin
            if (tbl_len[entry_idx] == 8'd0) state_nx = NEXT;
            else if (wr_ptr == BUF_FULL) begin
               state_nx  = DONE;
               set_trunc = 1'b1;
            end else state_nx = READ;
         end
         READ:  state_nx = STORE;
         STORE: begin
            if (!more_bytes) state_nx = NEXT;
            else if (wr_ptr + 1'b1 == BUF_FULL) begin
               state_nx  = DONE;
               set_trunc = 1'b1;
            end else state_nx = READ;
         end
         NEXT:  state_nx = (CNT_W'(entry_idx) + 1'b1 == entry_cnt) ? DONE : SETUP;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (abort && state inside {SETUP, READ, STORE, NEXT}) state_nx = IDLE;
   end

   assign rd_addr_full     = cur_base + 24'(offset);
   assign unused_addr_bits = ^rd_addr_full[23:RAM_AW];

   always_comb begin
      capture_busy = (state != IDLE);
      ram_read     = (state == READ);
      ram_address  = '0;
      if (state == READ) ram_address = rd_addr_full[RAM_AW-1:0];
   end

   // wr_ptr doubles as the stored byte count once the capture completes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         entry_idx    <= '0;
         wr_ptr       <= '0;
         offset       <= '0;
         cur_base     <= '0;
         cur_len      <= '0;
         capture_done <= 1'b0;
         truncated    <= 1'b0;
      end else begin
         if (state == IDLE && state_nx == SETUP) begin
            capture_done <= 1'b0;
            truncated    <= 1'b0;
            entry_idx    <= '0;
            wr_ptr       <= '0;
         end
         if (state == SETUP) begin
            cur_base <= {tbl_b1[entry_idx], tbl_b2[entry_idx], tbl_b3[entry_idx]};
            cur_len  <= tbl_len[entry_idx];
            offset   <= '0;
         end
         if (state == STORE) begin
            wr_ptr <= wr_ptr + 1'b1;
            offset <= offset + 8'd1;
         end
         if (state == NEXT && state_nx == SETUP) entry_idx <= entry_idx + 1'b1;
         if (state != DONE && state_nx == DONE) begin
            capture_done <= 1'b1;
            if (set_trunc) truncated <= 1'b1;
         end
         if (cfg_wr) capture_done <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ioctl.ioctl_din <= 8'h00;
      else if (capture_done && ioctl.ioctl_addr < 25'(wr_ptr))
         ioctl.ioctl_din <= cap_buf[ioctl.ioctl_addr[BUF_AW-1:0]];
      else
         ioctl.ioctl_din <= 8'h00;
   end

endmodule

// File: tb/tb_hiscore_save.sv
// Directed bench for hiscore_save: expected RAM reads and upload bytes are queued
// by the stimulus and compared by a monitor when the DUT presents them.
module tb_hiscore_save;

   logic       clk;
   logic       reset_n;
   logic       capture_req;
   logic       capture_busy, capture_done, truncated;
   logic [9:0] ram_address;
   logic       ram_read;
   logic [7:0] ram_data;

   hiscore_save_if bus ();

   hiscore_save #(.CFG_INDEX(3), .MAX_ENTRIES(16), .BUF_AW(5), .RAM_AW(10)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .ioctl        (bus.slave),
      .capture_req  (capture_req),
      .capture_busy (capture_busy),
      .capture_done (capture_done),
      .truncated    (truncated),
      .ram_address  (ram_address),
      .ram_read     (ram_read),
      .ram_data     (ram_data)
   );

   int checks = 0;
   int errors = 0;

   logic [9:0] exp_rd  [$];
   logic [7:0] exp_din [$];
   logic       up_req = 1'b0;
   logic       up_dly = 1'b0;
   logic [7:0] ram [1024];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Game RAM model: registered read, data valid the cycle after ram_read.
   always @(posedge clk) begin
      if (ram_read) ram_data <= ram[ram_address];
      up_dly <= up_req;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (ram_read) begin
         if (exp_rd.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ram_read actual=%h required=none", ram_address);
         end else check("ram_address", 32'(ram_address), 32'(exp_rd.pop_front()));
      end
      if (up_dly) begin
         if (exp_din.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_upload actual=%h required=none", bus.ioctl_din);
         end else check("ioctl_din", 32'(bus.ioctl_din), 32'(exp_din.pop_front()));
      end
   end

   task automatic cfg_byte(input int addr, input logic [7:0] data);
      @(negedge clk);
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = 25'(addr);
      bus.ioctl_dout = data;
      @(negedge clk);
      bus.ioctl_wr   = 1'b0;
   endtask

   task automatic load_rec(input int n, input logic [23:0] base, input logic [7:0] len);
      cfg_byte(n*8 + 0, 8'hEE);
      cfg_byte(n*8 + 1, base[23:16]);
      cfg_byte(n*8 + 2, base[15:8]);
      cfg_byte(n*8 + 3, base[7:0]);
      cfg_byte(n*8 + 4, len);
      cfg_byte(n*8 + 5, 8'hEE);
      cfg_byte(n*8 + 6, 8'hEE);
      cfg_byte(n*8 + 7, 8'h00);
   endtask

   task automatic cfg_begin();
      @(negedge clk);
      bus.ioctl_download = 1'b1;
      bus.ioctl_index    = 8'd3;
   endtask

   task automatic cfg_end();
      @(negedge clk);
      bus.ioctl_download = 1'b0;
      bus.ioctl_addr     = '0;
   endtask

   task automatic pulse_req();
      @(negedge clk);
      capture_req = 1'b1;
      @(negedge clk);
      capture_req = 1'b0;
   endtask

   task automatic wait_done(input string name, input int exp_cycles);
      int cyc = 0;
      while (!capture_done && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      check({name, "_done"}, 32'(capture_done), 32'd1);
      check({name, "_cycles"}, 32'(cyc), 32'(exp_cycles));
      @(negedge clk);
      check({name, "_idle"}, 32'(capture_busy), 32'd0);
   endtask

   task automatic up_check(input int addr, input logic [7:0] exp);
      @(negedge clk);
      bus.ioctl_upload = 1'b1;
      bus.ioctl_addr   = 25'(addr);
      exp_din.push_back(exp);
      up_req = 1'b1;
   endtask

   task automatic up_flush();
      @(negedge clk);
      up_req = 1'b0;
      @(negedge clk);
      bus.ioctl_upload = 1'b0;
      bus.ioctl_addr   = '0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
      ram[10'h00B] = 8'h11; ram[10'h00C] = 8'h22; ram[10'h00D] = 8'h33; ram[10'h00E] = 8'h44;
      ram[10'h023] = 8'hA1; ram[10'h024] = 8'hA2;
      ram[10'h100] = 8'hB1; ram[10'h101] = 8'hB2; ram[10'h102] = 8'hB3;
      for (int i = 0; i < 40; i++) ram[10'h200 + i] = 8'(i*7 + 3);

      reset_n            = 1'b0;
      capture_req        = 1'b0;
      bus.ioctl_download = 1'b0;
      bus.ioctl_upload   = 1'b0;
      bus.ioctl_wr       = 1'b0;
      bus.ioctl_addr     = '0;
      bus.ioctl_dout     = '0;
      bus.ioctl_index    = '0;
      #12;
      check("rst_busy", 32'(capture_busy), 32'd0);
      check("rst_done", 32'(capture_done), 32'd0);
      check("rst_trunc", 32'(truncated), 32'd0);
      check("rst_ram_read", 32'(ram_read), 32'd0);
      check("rst_ram_address", 32'(ram_address), 32'd0);
      check("rst_din", 32'(bus.ioctl_din), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // No config loaded: request must be ignored.
      pulse_req();
      repeat (3) begin
         check("nocfg_busy", 32'(capture_busy), 32'd0);
         @(negedge clk);
      end

      // Single record, 4 bytes at 0x00B.
      cfg_begin();
      load_rec(0, 24'h00000B, 8'h04);
      cfg_end();
      for (int i = 0; i < 4; i++) exp_rd.push_back(10'h00B + 10'(i));
      pulse_req();
      wait_done("one", 10);
      check("one_trunc", 32'(truncated), 32'd0);
      up_check(0, 8'h11); up_check(1, 8'h22); up_check(2, 8'h33);
      up_check(3, 8'h44); up_check(4, 8'h00);
      up_flush();

      // Two records; a new download clears the previous snapshot.
      cfg_begin();
      load_rec(0, 24'h000023, 8'h02);
      load_rec(1, 24'h000100, 8'h03);
      cfg_end();
      check("two_done_cleared", 32'(capture_done), 32'd0);
      exp_rd.push_back(10'h023); exp_rd.push_back(10'h024);
      exp_rd.push_back(10'h100); exp_rd.push_back(10'h101); exp_rd.push_back(10'h102);
      pulse_req();
      wait_done("two", 14);
      check("two_trunc", 32'(truncated), 32'd0);
      up_check(0, 8'hA1); up_check(1, 8'hA2); up_check(2, 8'hB1);
      up_check(3, 8'hB2); up_check(4, 8'hB3); up_check(5, 8'h00);
      up_flush();

      // Oversized record: 40 bytes requested, buffer holds 32.
      cfg_begin();
      load_rec(0, 24'h000200, 8'h28);
      cfg_end();
      for (int i = 0; i < 32; i++) exp_rd.push_back(10'h200 + 10'(i));
      pulse_req();
      wait_done("trunc", 65);
      check("trunc_flag", 32'(truncated), 32'd1);
      up_check(0, 8'd3); up_check(31, 8'(31*7 + 3)); up_check(32, 8'h00);
      up_flush();

      // Upload asserted mid-capture aborts it.
      exp_rd.push_back(10'h200); exp_rd.push_back(10'h201); exp_rd.push_back(10'h202);
      pulse_req();
      repeat (5) @(negedge clk);
      bus.ioctl_upload = 1'b1;
      @(negedge clk);
      check("abort_busy", 32'(capture_busy), 32'd0);
      check("abort_done", 32'(capture_done), 32'd0);
      check("abort_ram_read", 32'(ram_read), 32'd0);
      up_check(0, 8'h00); up_check(1, 8'h00);
      up_flush();

      // Asynchronous reset between edges during a read cycle.
      exp_rd.push_back(10'h200); exp_rd.push_back(10'h201);
      pulse_req();
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("arst_busy", 32'(capture_busy), 32'd0);
      check("arst_ram_read", 32'(ram_read), 32'd0);
      check("arst_ram_address", 32'(ram_address), 32'd0);
      check("arst_done", 32'(capture_done), 32'd0);
      check("arst_trunc", 32'(truncated), 32'd0);
      check("arst_din", 32'(bus.ioctl_din), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      pulse_req();
      repeat (2) begin
         check("arst_cnt_cleared", 32'(capture_busy), 32'd0);
         @(negedge clk);
      end

      // Restart with a zero-length entry that must be skipped.
      cfg_begin();
      load_rec(0, 24'h0003FF, 8'h00);
      load_rec(1, 24'h00000B, 8'h01);
      cfg_end();
      exp_rd.push_back(10'h00B);
      pulse_req();
      wait_done("skip", 6);
      check("skip_trunc", 32'(truncated), 32'd0);
      up_check(0, 8'h11); up_check(1, 8'h00);
      up_flush();

      repeat (2) @(negedge clk);
      check("reads_outstanding", 32'(exp_rd.size()), 32'd0);
      check("uploads_outstanding", 32'(exp_din.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/hiscore_save.md
HISCORE_SAVE -- requirements
Module: hiscore_save

Interface
REQ-001 Parameters SHALL be: CFG_INDEX, default 3, ioctl_index of the hiscore config table; MAX_ENTRIES, default 16, config records held; BUF_AW, default 5, capture buffer address width (32 bytes); RAM_AW, default 10, game RAM address width.
REQ-002 Ports SHALL be: clk  in  1  system clock, all logic rising-edge.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 ioctl_download  in  1  download in progress.
REQ-005 ioctl_upload  in  1  upload (save to host) in progress.
REQ-006 ioctl_wr  in  1  download byte strobe.
REQ-007 ioctl_addr  in  25  byte address of current download/upload byte.
REQ-008 ioctl_dout  in  8  download data byte.
REQ-009 ioctl_index  in  8  download stream selector.
REQ-010 ioctl_din  out  8  upload data byte returned to host.
REQ-011 capture_req  in  1  single-cycle pulse, snapshot hiscore RAM into buffer.
REQ-012 capture_busy  out  1  capture in progress.
REQ-013 capture_done  out  1  buffer holds a valid snapshot.
REQ-014 truncated  out  1  last capture exceeded buffer size.
REQ-015 ram_address  out  RAM_AW  game RAM read address.
REQ-016 ram_read  out  1  game RAM read strobe; ram_data valid the following cycle.
REQ-017 ram_data  in  8  game RAM read data.
REQ-018 One clock; reset is asynchronous and active-low (clk, reset_n).

Function
REQ-019 Config load: when ioctl_download & ioctl_wr & ioctl_index==CFG_INDEX, record n=ioctl_addr[6:3], byte k=ioctl_addr[2:0]; bytes 1..3 SHALL form the 24-bit base address (byte1 MSB), byte4 the length, bytes 0,5,6,7 ignored.
REQ-020 Entry count SHALL equal 1 + highest n whose byte4 was written during the most recent CFG_INDEX download; a new CFG_INDEX download SHALL reset the count to 0 at its first write.
REQ-021 Entries with length 0 SHALL be skipped without RAM reads.
REQ-022 FSM states: IDLE, SETUP, READ, STORE, NEXT, DONE.
REQ-023 IDLE -> SETUP on capture_req when entry count > 0 and ioctl_download==0 and ioctl_upload==0; otherwise capture_req SHALL be ignored.
REQ-024 On leaving IDLE, capture_done and truncated SHALL clear, entry index and buffer write pointer SHALL clear to 0.
REQ-025 SETUP (1 cycle): latch base/length of current entry, byte offset=0.
REQ-026 READ: ram_address = (base + offset)[RAM_AW-1:0], ram_read=1 for exactly one cycle, -> STORE.
REQ-027 STORE: write ram_data to buffer[write pointer], increment pointer and offset; -> READ if offset < length, else -> NEXT. Throughput: 2 cycles per byte.
REQ-028 NEXT: if entry index+1 == entry count -> DONE, else increment index -> SETUP.
REQ-029 If write pointer reaches 2^BUF_AW with bytes remaining, truncated SHALL set and FSM -> DONE; no buffer wrap.
REQ-030 DONE: capture_done=1, stored byte count latched, -> IDLE next cycle; capture_done SHALL remain 1 until next capture starts or config download.
REQ-031 capture_busy SHALL be 1 in every state except IDLE.
REQ-032 Any ioctl_download or ioctl_upload assertion during capture SHALL abort to IDLE with capture_done=0.
REQ-033 Upload: ioctl_din SHALL be registered, one cycle after ioctl_addr changes: buffer[ioctl_addr[BUF_AW-1:0]] if capture_done and ioctl_addr < stored count, else 0x00.
REQ-034 ram_read SHALL be 0 outside READ.

Reset
REQ-035 reset_n low SHALL immediately force IDLE, ioctl_din=0, capture_busy=0, capture_done=0, truncated=0, ram_read=0, ram_address=0, entry count=0; buffer and table contents undefined.

Verification
REQ-036 Load record 0 = 00 00 00 0B 04 xx xx 00, preload RAM 0x00B..0x00E = 11 22 33 44, pulse capture_req -> ram_read at 0x00B..0x00E, capture_done after 10 cycles, upload addr 0..4 returns 11 22 33 44 00.
REQ-037 Two records (0x023 len 2, 0x100 len 3) -> buffer = RAM[0x023..0x024] then RAM[0x100..0x102], stored count 5, truncated=0.
REQ-038 Record len 0x28 -> exactly 32 bytes stored, truncated=1, capture_done=1, upload addr 32 returns 00.
REQ-039 Assert ioctl_upload mid-capture -> capture_busy falls next cycle, capture_done=0, upload returns 00.
REQ-040 capture_req with no config loaded -> no ram_read, capture_busy stays 0.
REQ-041 reset_n low mid-capture (async, between edges) -> outputs zero immediately; after release capture_req restarts cleanly.
